// File: rtl/ps2_host_tx.sv
// Purpose: PS/2 host-to-device command transmitter (request-to-send, 11-clock frame, ack capture).
// Latency: ps2c pulled low the cycle after an accepted wr_ps2; ps2d updates one cycle after a filtered fall.
// Backpressure: wr_ps2 accepted only while tx_idle=1; writes while busy are dropped, never queued.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int RTS_CYCLES     = 10000,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       wr_ps2,
    input  logic [7:0] din,
    inout  wire        ps2c,
    inout  wire        ps2d,
    output logic       tx_idle,
    output logic       tx_done_tick,
    output logic       ack_err
);

    localparam int CW = $clog2(RTS_CYCLES + 1);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RTS, S_START, S_DATA, S_STOP, S_WAIT
    } state_t;

    state_t                state_q, state_d;
    logic [8:0]            shreg_q, shreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [3:0]            n_q, n_d;
    logic [WW-1:0]         wdog_q, wdog_d;
    logic                  ack_err_q, ack_err_d;
    logic [FILTER_LEN-1:0] filt_q;
    logic                  level_q, level_now, fall;
    logic                  ps2d_s1_q, ps2d_s_q;
    logic                  active, timeout, wait_done;
    logic                  c_drive, d_drive;

    // Open-drain pads: only ever pull low, otherwise float for the pull-up.
    assign ps2c = c_drive ? 1'b0 : 1'bz;
    assign ps2d = d_drive ? 1'b0 : 1'bz;

    // Clock glitch filter: level only changes once FILTER_LEN identical samples are seen.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            filt_q  <= '1;
            level_q <= 1'b1;
        end else begin
            filt_q  <= {ps2c, filt_q[FILTER_LEN-1:1]};
            level_q <= level_now;
        end
    end

    // Filtered level and its falling edge, derived from the current filter contents.
    always_comb begin
        level_now = level_q;
        if (&filt_q)       level_now = 1'b1;
        else if (~|filt_q) level_now = 1'b0;
        fall = level_q & ~level_now;
    end

    // Two-flop synchroniser for the data line read-back (ack and bus-idle detection).
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            ps2d_s1_q <= 1'b1;
            ps2d_s_q  <= 1'b1;
        end else begin
            ps2d_s1_q <= ps2d;
            ps2d_s_q  <= ps2d_s1_q;
        end
    end

    assign active    = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_STOP)  || (state_q == S_WAIT);
    assign timeout   = active && (wdog_q == WW'(TIMEOUT_CYCLES - 1));
    assign wait_done = (state_q == S_WAIT) && level_now && ps2d_s_q;

    // FSM state register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Datapath registers: frame shifter, RTS counter, bit counter, watchdog, status.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            n_q       <= '0;
            wdog_q    <= '0;
            ack_err_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            wdog_q    <= wdog_d;
            ack_err_q <= ack_err_d;
        end
    end

    // Next-state and datapath update; the watchdog overrides every active state.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        n_d       = n_q;
        wdog_d    = wdog_q;
        ack_err_d = ack_err_q;
        if (active) wdog_d = wdog_q + WW'(1);
        case (state_q)
            S_IDLE: begin
                if (wr_ps2) begin
                    shreg_d   = {~^din, din};
                    cnt_d     = CW'(RTS_CYCLES - 1);
                    ack_err_d = 1'b0;
                    state_d   = S_RTS;
                end
            end
            S_RTS: begin
                if (cnt_q == '0) begin
                    wdog_d  = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_START: begin
                if (fall) begin
                    n_d     = 4'd8;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fall) begin
                    if (n_q != 4'd0) begin
                        shreg_d = {1'b0, shreg_q[8:1]};
                        n_d     = n_q - 4'd1;
                    end else begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (fall) begin
                    ack_err_d = ps2d_s_q;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (timeout) begin
            ack_err_d = 1'b1;
            state_d   = S_IDLE;
        end
    end

    // Outputs and line drives decoded from the current state.
    always_comb begin
        tx_idle      = (state_q == S_IDLE);
        tx_done_tick = timeout || wait_done;
        c_drive      = (state_q == S_RTS);
        d_drive      = (state_q == S_START) || ((state_q == S_DATA) && !shreg_q[0]);
        ack_err      = ack_err_q;
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int RTS  = 100;
    localparam int TMO  = 20000;
    localparam int HALF = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr;
    logic [7:0] din;
    wire        ps2c;
    wire        ps2d;
    logic       tx_idle, done, ack_err;
    logic       dev_c_low = 1'b0;
    logic       dev_d_low = 1'b0;

    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;
    pullup (ps2c);
    pullup (ps2d);

    always #5 clk = ~clk;

    ps2_host_tx #(.RTS_CYCLES(RTS), .FILTER_LEN(8), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .Reset(rst), .wr_ps2(wr), .din(din),
        .ps2c(ps2c), .ps2d(ps2d),
        .tx_idle(tx_idle), .tx_done_tick(done), .ack_err(ack_err)
    );

    typedef struct {
        logic        ack;
        logic        frame;
        logic [10:0] bits;
    } exp_t;

    exp_t        exp_q[$];
    logic [10:0] cap_q[$];
    int          n_chk  = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // start 0, data LSB first, parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b, input logic par);
        return {1'b1, par, b, 1'b0};
    endfunction

    function automatic exp_t mk(input logic a, input logic f, input logic [7:0] b, input logic par);
        exp_t e;
        e.ack = a; e.frame = f; e.bits = frame_of(b, par);
        return e;
    endfunction

    // Scoreboard monitor: every done tick consumes one expectation.
    initial begin : monitor
        exp_t e;
        logic have;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                check("idle_low_at_done", tx_idle, 0);
                check("done_was_expected", exp_q.size() > 0, 1);
                have = (exp_q.size() > 0);
                if (have) e = exp_q.pop_front();
                @(negedge clk);
                check("done_one_cycle", done, 0);
                check("idle_after_done", tx_idle, 1);
                if (have) begin
                    check("ack_err", ack_err, e.ack);
                    if (e.frame) begin
                        check("frame_captured", cap_q.size() > 0, 1);
                        if (cap_q.size() > 0) check("frame_bits", cap_q.pop_front(), e.bits);
                    end
                end
            end
        end
    end

    initial begin : global_guard
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "global timeout");
    end

    task automatic write(input logic [7:0] b);
        wr = 1'b1; din = b;
        @(negedge clk);
        wr = 1'b0;
    endtask

    // mode 0: normal with ack, 1: no ack, 2: silent after RTS, 3: glitch in START then ack
    task automatic device(input int mode);
        logic [10:0] bits;
        int cnt;
        cnt = 0;
        while (ps2c === 1'b0 && cnt < 2*RTS) begin
            cnt++;
            @(negedge clk);
        end
        check("rts_low_cycles", cnt, RTS);
        check("start_bit_driven", ps2d, 0);
        check("busy_in_start", tx_idle, 0);
        if (mode == 2) begin
            cnt = 0;
            while (tx_idle !== 1'b1 && cnt < TMO + 100) begin
                @(negedge clk);
                cnt++;
            end
            check("timeout_cycles", cnt, TMO);
            check("timeout_ps2c_z", ps2c, 1);
            check("timeout_ps2d_z", ps2d, 1);
            return;
        end
        repeat (50) @(negedge clk);
        if (mode == 3) begin
            dev_c_low = 1'b1;
            repeat (3) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (50) @(negedge clk);
            check("glitch_still_start", {tx_idle, ps2d}, 2'b00);
        end
        bits[0] = ps2d;
        for (int k = 1; k <= 10; k++) begin
            dev_c_low = 1'b1;
            repeat (HALF) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (HALF/2) @(negedge clk);
            bits[k] = ps2d;
            repeat (HALF/2) @(negedge clk);
        end
        cap_q.push_back(bits);
        if (mode != 1) dev_d_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (20) @(negedge clk);
        dev_d_low = 1'b0;
        cnt = 0;
        while (tx_idle !== 1'b1 && cnt < 1000) begin
            @(negedge clk);
            cnt++;
        end
        check("returned_idle", tx_idle, 1);
    endtask

    logic [7:0] vec_b[4] = '{8'hED, 8'h00, 8'hFF, 8'h01};
    logic       vec_p[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    initial begin : stim
        int cnt;
        rst = 1'b1; wr = 1'b0; din = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_idle", tx_idle, 1);
        check("rst_done", done, 0);
        check("rst_ack_err", ack_err, 0);
        check("rst_ps2c_z", ps2c, 1);
        check("rst_ps2d_z", ps2d, 1);
        rst = 1'b0;
        @(negedge clk);

        // Directed bytes, back-to-back (each write lands in the first idle cycle).
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(mk(1'b0, 1'b1, vec_b[i], vec_p[i]));
            write(vec_b[i]);
            device(0);
        end

        // Missing ack: 0xF4 has five ones, odd parity bit 0.
        exp_q.push_back(mk(1'b1, 1'b1, 8'hF4, 1'b0));
        write(8'hF4);
        device(1);

        // Device silent after RTS: watchdog ends the transfer.
        exp_q.push_back(mk(1'b1, 1'b0, 8'hFF, 1'b1));
        write(8'hFF);
        device(2);
        @(negedge clk);

        // Second write mid-frame is dropped; 0x55 has four ones, parity 1.
        exp_q.push_back(mk(1'b0, 1'b1, 8'h55, 1'b1));
        write(8'h55);
        fork
            device(0);
            begin
                repeat (RTS + 2000) @(negedge clk);
                wr = 1'b1; din = 8'hAA;
                @(negedge clk);
                wr = 1'b0;
            end
        join
        repeat (500) @(negedge clk);
        check("ignored_write_idle", tx_idle, 1);
        check("ignored_write_ps2c", ps2c, 1);

        // Short glitch in START must not advance the frame; 0x3C parity 1.
        exp_q.push_back(mk(1'b0, 1'b1, 8'h3C, 1'b1));
        write(8'h3C);
        device(3);

        // Asynchronous reset while driving a data bit.
        write(8'h00);
        cnt = 0;
        while (ps2c === 1'b0 && cnt < 2*RTS) begin
            cnt++;
            @(negedge clk);
        end
        repeat (50) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (HALF) @(negedge clk);
        dev_c_low = 1'b0;
        repeat (HALF/2) @(negedge clk);
        check("data_d0_driven", ps2d, 0);
        check("busy_in_data", tx_idle, 0);
        #1 rst = 1'b1;
        #1;
        check("reset_ps2d_z", ps2d, 1);
        check("reset_ps2c_z", ps2c, 1);
        check("reset_idle", tx_idle, 1);
        check("reset_no_done", done, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_reset_ack_err", ack_err, 0);

        // Recovery after reset.
        exp_q.push_back(mk(1'b0, 1'b1, 8'hED, 1'b1));
        write(8'hED);
        device(0);

        repeat (50) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        check("captures_drained", cap_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
